// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment display sharing one external hex-to-segment decoder.
// Provides frame-synchronous value loading, leading-zero blanking and
// all-anodes-off dead time between digits.
// Optional build macro: SEG_SCAN_BLINK_EN adds per-digit blinking
// (blink_mask input, BLINK_DIV parameter).
module seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 16,
    parameter int CNT_W       = 16
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV   = 25000000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lead,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            data,
    input  logic [6:0]            seg_in,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0    = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {DEAD, ACTIVE} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [4*DIGITS-1:0]  pending, pending_next;
    logic [4*DIGITS-1:0]  shadow, shadow_next;
    logic [3:0]           data_next;
    logic [6:0]           seg_next;
    logic [DIGITS-1:0]    an_next;
    logic                 dp_next;
    logic                 fs_next;
    logic [DIGITS-1:0]    lead_zero;
    logic                 all_zero;

    function automatic logic [3:0] nibble_of(input logic [4*DIGITS-1:0] v,
                                             input logic [IDX_W-1:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

`ifdef SEG_SCAN_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_ph;

    // Free-running blink phase: toggles every BLINK_DIV clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end
`endif

    // A digit is a leading zero when it and every more significant digit are 0;
    // digit 0 always shows, so a zero value still displays "0"
    always_comb begin
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero && (shadow[4*k +: 4] == 4'h0);
            lead_zero[k] = all_zero;
        end
        lead_zero[0] = 1'b0;
    end

    // Next-state and registered-output logic; outputs reflect the current
    // state/idx one cycle later, so anode and segments always switch together
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        shadow_next  = shadow;
        pending_next = load ? value : pending;
        an_next      = '1;
        seg_next     = 7'h7F;
        dp_next      = 1'b1;
        fs_next      = 1'b0;

        case (state)
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACTIVE: begin
                an_next  = ~(ONE_HOT0 << idx);
                seg_next = (blank_lead && lead_zero[idx]) ? 7'h7F : seg_in;
                dp_next  = ~dp_in[idx];
                fs_next  = (idx == '0) && (cnt == '0);
`ifdef SEG_SCAN_BLINK_EN
                if (blink_mask[idx] && blink_ph) begin
                    seg_next = 7'h7F;
                    dp_next  = 1'b1;
                end
`endif
                if (cnt == REFRESH_LAST) begin
                    state_next = DEAD;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        shadow_next = pending;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = DEAD;
                cnt_next   = '0;
            end
        endcase

        data_next = nibble_of(shadow_next, idx_next);
    end

    // State and output registers; reset leaves shadow equal to pending (both 0),
    // which is exactly what loading on the first dead phase would give
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DEAD;
            cnt         <= '0;
            idx         <= '0;
            pending     <= '0;
            shadow      <= '0;
            data        <= 4'h0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            pending     <= pending_next;
            shadow      <= shadow_next;
            data        <= data_next;
            an          <= an_next;
            seg         <= seg_next;
            dp          <= dp_next;
            frame_start <= fs_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (default build).
// Models the shared decoder and predicts every output from the frame position.
module tb_seg_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int DEAD_CYC    = 1;
    localparam int CNT_W       = 4;
    localparam int SLOT        = REFRESH_DIV + DEAD_CYC;
    localparam int PERIOD      = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lead;
    logic [3:0]  dp_in;
    logic [3:0]  data;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int compared   = 0;
    int mismatched = 0;

    int          mS;
    logic [15:0] mPending;
    logic [15:0] mShadow;

    typedef struct {
        logic [15:0]     value;
        logic            bl;
        logic [3:0]      dpin;
        logic [3:0][6:0] es;
        logic [3:0]      edp;
    } vec_t;

    vec_t vecs[7];

    // Clock generation
    always #5 clk = ~clk;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Shared external decoder
    assign seg_in = hexSeg(data);

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .DEAD_CYC(DEAD_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lead(blank_lead),
        .dp_in(dp_in), .data(data), .seg_in(seg_in), .seg(seg), .an(an), .dp(dp),
        .frame_start(frame_start)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: predict the outputs after this edge, advance, compare
    task automatic tick();
        logic [3:0]  xAn;
        logic [6:0]  xSeg;
        logic        xDp;
        logic        xFs;
        logic [3:0]  xData;
        logic [15:0] sh;
        int pos, dig, w, nd;
        xAn = 4'hF; xSeg = 7'h7F; xDp = 1'b1; xFs = 1'b0; xData = 4'h0;
        if (rst) begin
            mS = 0; mPending = '0; mShadow = '0;
        end else begin
            pos = mS % PERIOD;
            dig = pos / SLOT;
            w   = pos % SLOT;
            if (w >= DEAD_CYC) begin
                xAn[dig] = 1'b0;
                sh = mShadow >> (4 * dig);
                xSeg = (blank_lead && dig > 0 && sh == 16'h0) ? 7'h7F : hexSeg(sh[3:0]);
                xDp = ~dp_in[dig];
                xFs = (dig == 0) && (w == DEAD_CYC);
            end
            if ((mS + 1) % PERIOD == 0) mShadow = mPending;
            if (load) mPending = value;
            nd = ((mS + 1) % PERIOD) / SLOT;
            sh = mShadow >> (4 * nd);
            xData = sh[3:0];
            mS++;
        end
        @(posedge clk);
        #1;
        checkOutput("model_an", 32'(an), 32'(xAn));
        checkOutput("model_seg", 32'(seg), 32'(xSeg));
        checkOutput("model_dp", 32'(dp), 32'(xDp));
        checkOutput("model_fs", 32'(frame_start), 32'(xFs));
        checkOutput("model_data", 32'(data), 32'(xData));
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                                 input logic b, input logic [3:0] d);
        rst = r; load = l; value = v; blank_lead = b; dp_in = d;
        tick();
        load = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic waitFrameStart();
        int n = 0;
        load = 1'b0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 3 * PERIOD);
        if (!frame_start) checkOutput("fs_timeout", 32'(frame_start), 32'd1);
    endtask

    // Check one full frame starting at the current frame_start cycle
    task automatic captureFrame(input logic [3:0][6:0] es, input logic [3:0] edp,
                                input int loadA, input logic [15:0] valA,
                                input int loadB, input logic [15:0] valB, input string tag);
        int lit[4];
        int kk;
        for (int k = 0; k < 4; k++) lit[k] = 0;
        for (int c = 0; c < PERIOD; c++) begin
            if (c > 0) begin
                load = (c == loadA) || (c == loadB);
                if (c == loadA) value = valA;
                if (c == loadB) value = valB;
                tick();
                load = 1'b0;
            end
            if (an != 4'hF) begin
                kk = 0;
                for (int k = 0; k < 4; k++) if (!an[k]) kk = k;
                checkOutput({tag, "_seg"}, 32'(seg), 32'(es[kk]));
                checkOutput({tag, "_dp"}, 32'(dp), 32'(edp[kk]));
                lit[kk]++;
            end
        end
        for (int k = 0; k < 4; k++) checkOutput({tag, "_litcycles"}, 32'(lit[k]), 32'(REFRESH_DIV));
    endtask

    initial begin
        int n, allOff, zeros;

        vecs[0] = '{16'h1234, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0050, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[4] = '{16'hBBBB, 1'b0, 4'b0100, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1011};
        vecs[5] = '{16'h0A0F, 1'b1, 4'b0000, {7'h7F, 7'h08, 7'h40, 7'h0E}, 4'b1111};
        vecs[6] = '{16'h89CD, 1'b0, 4'b1001, {7'h00, 7'h10, 7'h46, 7'h21}, 4'b0110};

        rst = 1'b1; load = 1'b0; value = '0; blank_lead = 1'b0; dp_in = '0;
        mS = 0; mPending = '0; mShadow = '0;

        // Reset for two cycles and check reset values
        tick();
        tick();
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dp", 32'(dp), 32'd1);
        checkOutput("rst_fs", 32'(frame_start), 32'd0);
        checkOutput("rst_data", 32'(data), 32'd0);

        // Load 1234 right after reset: first frame 0000, next frame 1234
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 4'b0000);
        waitFrameStart();
        captureFrame({4{7'h40}}, 4'hF, -1, '0, -1, '0, "frame0");
        waitFrameStart();
        captureFrame(vecs[0].es, 4'hF, -1, '0, -1, '0, "frame1");

        // Table-driven display checks
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, vecs[i].value, vecs[i].bl, vecs[i].dpin);
            waitFrameStart();
            waitFrameStart();
            captureFrame(vecs[i].es, vecs[i].edp, -1, '0, -1, '0, $sformatf("vec%0d", i));
        end

        // Frame period, one-hot anodes, one dead cycle per digit
        waitFrameStart();
        n = 0; allOff = 0;
        do begin
            tick();
            n++;
            zeros = 0;
            for (int k = 0; k < 4; k++) if (!an[k]) zeros++;
            checkOutput("an_onehot", 32'(zeros <= 1), 32'd1);
            if (an == 4'hF) allOff++;
        end while (!frame_start && n < 3 * PERIOD);
        checkOutput("frame_period", 32'(n), 32'(PERIOD));
        checkOutput("dead_cycles", 32'(allOff), 32'(DIGITS * DEAD_CYC));

        // Two loads mid-frame: current frame unchanged, next frame shows the last one
        dp_in = 4'b0100;
        waitFrameStart();
        captureFrame(vecs[6].es, 4'b1011, 5, 16'hAAAA, 9, 16'hBBBB, "curframe");
        waitFrameStart();
        captureFrame({4{7'h03}}, 4'b1011, -1, '0, -1, '0, "nextframe");

        // Reset while digit 2 is lit, with a pending load that must be lost
        dp_in = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (an != 4'b1011 && n < 3 * PERIOD);
        checkOutput("wait_digit2", 32'(an), 32'hB);
        applyStimulus(1'b0, 1'b1, 16'h7777, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
        checkOutput("midrst_an", 32'(an), 32'hF);
        checkOutput("midrst_seg", 32'(seg), 32'h7F);
        checkOutput("midrst_data", 32'(data), 32'd0);
        checkOutput("midrst_dp", 32'(dp), 32'd1);
        waitFrameStart();
        captureFrame({4{7'h40}}, 4'hF, -1, '0, -1, '0, "afterrst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) blank_lead = 1'($urandom);
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
                          16'($urandom), blank_lead, dp_in);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
